approx_lookahead_adder_pipe: RTL and testbench
==============================================

Name: approx_lookahead_adder_pipe

Overview:
- Segmented approximate adder built around the one-bit lookahead carry calculator. It sits directly downstream of that calculator and consumes the speculative carries it produces.
- Operands are split into SEG-bit segments:
  - segment 0 takes the external carry C0;
  - every other segment takes a speculative carry predicted from the two bits below the segment boundary.
- Two-stage valid/ready pipeline, plus an exact-sum checker and a saturating error counter for accuracy characterisation.

Parameters:
- WIDTH, 16, operand and sum width. Must be a multiple of SEG.
- SEG, 4, segment width. Must be at least 2.
- CNT_W, 16, width of the error counter.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST_N  input  1  synchronous, active-low reset.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C0  input  1  carry-in to segment 0.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- S  output  WIDTH  approximate sum.
- COUT  output  1  carry-out of the top segment (approximate).
- ERR  output  1  set when {COUT,S} differs from the exact A+B+C0.
- CNT_CLR  input  1  synchronous clear of ERR_CNT.
- ERR_CNT  output  CNT_W  count of delivered results with ERR=1, saturating.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-low (RST_N); it is sampled only on the CLK rising edge.
- Values while RST_N is low at an edge:
  - both stage valids clear, so OUT_VALID=0;
  - S=0, COUT=0, ERR=0, ERR_CNT=0;
  - IN_READY is forced 0 while RST_N=0.
  - In-flight data is discarded; there is no flush handshake.
- Handshakes:
  - Input transfer occurs when IN_VALID&IN_READY; output transfer occurs when OUT_VALID&OUT_READY.
  - adv2 = !v2 | OUT_READY.
  - IN_READY = RST_N & (!v1 | adv2), a combinational path from OUT_READY.
- Stage 1, on input transfer:
  - registers A, B, C0;
  - computes segment carry-ins for i = 1..WIDTH/SEG-1, with k = i*SEG-1: cin_i = (A[k]&B[k]) | ((A[k]^B[k]) & A[k-1]&B[k-1]). This is the lookahead calculator with G=A[k]&B[k], P=A[k]^B[k] and its C0 driven by G of bit k-1.
  - cin_0 = C0.
  - All cin values are registered with the operands.
  - If stage 1 is full and no input arrives while adv2 is high, v1 clears.
- Stage 2, on adv2 & v1:
  - each segment performs an exact SEG-bit ripple add of its operand bits plus cin_i;
  - segment carry-outs are discarded except the top one, which drives COUT;
  - the exact (WIDTH+1)-bit sum of A+B+C0 is computed in parallel; ERR = ({COUT,S} != exact).
- Timing and ordering:
  - Latency is 2 cycles from input transfer to OUT_VALID with no backpressure.
  - Throughput is 1 per cycle; order is preserved.
- Backpressure:
  - While OUT_VALID & !OUT_READY, S, COUT and ERR hold stable.
  - The pipeline holds at most 2 transactions. IN_READY drops only when both stages are full and OUT_READY=0.
- Counter:
  - On output transfer with ERR=1, ERR_CNT increments; it saturates at 2^CNT_W-1 with no wrap.
  - CNT_CLR=1 forces ERR_CNT to 0 and takes priority. An error transfer in the same cycle is not counted.
- Arithmetic is unsigned; there is no overflow flag beyond COUT.

Test Plan:
- WIDTH=16, SEG=4. A=0x1234, B=0x4321, C0=0 -> two cycles later OUT_VALID=1, S=0x5555, COUT=0, ERR=0.
- A=0x000C, B=0x000C, C0=0 (bit-3 generate hits) -> cin_1=1, S=0x0018, COUT=0, ERR=0.
- A=0xFFFF, B=0x0000, C0=1 (long propagate chain) -> S=0xFFF0, COUT=0, ERR=1; exact result is {1,0x0000}.
- Backpressure:
  - Hold OUT_READY=0 and offer 3 back-to-back operands -> first 2 accepted, IN_READY=0 on the third, outputs stable.
  - Raise OUT_READY -> results delivered in order on consecutive cycles and the third operand is accepted.
- Counter:
  - Deliver 3 ERR=1 results -> ERR_CNT=3.
  - CNT_CLR pulsed in the same cycle as an ERR=1 transfer -> ERR_CNT=0.
  - Run with CNT_W=2 and 5 errors -> ERR_CNT=3.
- Reset mid-operation: RST_N=0 for one edge with both stages full -> OUT_VALID=0, ERR_CNT=0, S=0, IN_READY=0 during reset and 1 on the first cycle after release.

Source files
------------

// File: rtl/approx_lookahead_adder_pipe_if.sv
// Operand/result bundle for the segmented approximate adder pipeline.
// Transfers: IN_VALID&IN_READY moves operands in, OUT_VALID&OUT_READY moves a result out;
// a valid, once raised, holds its payload stable until the matching ready is seen.
interface approx_lookahead_adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] S;
    logic             COUT;
    logic             ERR;
    logic             CNT_CLR;
    logic [CNT_W-1:0] ERR_CNT;

    modport master (
        output IN_VALID, A, B, C0, OUT_READY, CNT_CLR,
        input  IN_READY, OUT_VALID, S, COUT, ERR, ERR_CNT
    );

    modport slave (
        input  IN_VALID, A, B, C0, OUT_READY, CNT_CLR,
        output IN_READY, OUT_VALID, S, COUT, ERR, ERR_CNT
    );
endinterface

// File: rtl/approx_lookahead_adder_pipe.sv
// Two-stage segmented approximate adder: speculative segment carries in stage 1,
// per-segment ripple adds plus exact-sum error check and saturating error counter in stage 2.
module approx_lookahead_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int CNT_W = 16
) (
    input logic CLK,
    input logic RST_N,
    approx_lookahead_adder_pipe_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;

    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c0_q;
    logic [NSEG-1:0]  cin_q;
    logic [NSEG-1:0]  cin_d;
    logic             adv2;
    logic             in_ready;
    logic             in_xfer;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic [SEG:0]     seg_sum;
    logic [WIDTH:0]   exact_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    assign adv2     = !v2 || bus.OUT_READY;
    assign in_ready = RST_N && (!v1 || adv2);
    assign in_xfer  = bus.IN_VALID && in_ready;

    // Segment carry-in predicted from generate at bit k, or propagate at k with generate at k-1.
    always_comb begin
        cin_d    = '0;
        cin_d[0] = bus.C0;
        for (int i = 1; i < NSEG; i++) begin
            cin_d[i] = (bus.A[i*SEG-1] & bus.B[i*SEG-1]) |
                       ((bus.A[i*SEG-1] ^ bus.B[i*SEG-1]) & bus.A[i*SEG-2] & bus.B[i*SEG-2]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v1    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            c0_q  <= 1'b0;
            cin_q <= '0;
        end else if (in_xfer) begin
            v1    <= 1'b1;
            a_q   <= bus.A;
            b_q   <= bus.B;
            c0_q  <= bus.C0;
            cin_q <= cin_d;
        end else if (adv2) begin
            v1 <= 1'b0;
        end
    end

    // Only the top segment's carry-out survives; lower carries are replaced by the prediction.
    always_comb begin
        s_d     = '0;
        cout_d  = 1'b0;
        seg_sum = '0;
        for (int i = 0; i < NSEG; i++) begin
            seg_sum = {1'b0, a_q[i*SEG +: SEG]} + {1'b0, b_q[i*SEG +: SEG]} +
                      {{SEG{1'b0}}, cin_q[i]};
            s_d[i*SEG +: SEG] = seg_sum[SEG-1:0];
            cout_d = seg_sum[SEG];
        end
    end

    assign exact_d = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c0_q};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v2     <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s_q    <= s_d;
                cout_q <= cout_d;
                err_q  <= ({cout_d, s_d} != exact_d);
            end
        end
    end

    // Clear wins over a coincident error delivery.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (bus.CNT_CLR) begin
            cnt_q <= '0;
        end else if (v2 && bus.OUT_READY && err_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = v2;
    assign bus.S         = s_q;
    assign bus.COUT      = cout_q;
    assign bus.ERR       = err_q;
    assign bus.ERR_CNT   = cnt_q;
endmodule

// File: tb/tb_approx_lookahead_adder_pipe.sv
// Directed bench for the segmented approximate adder pipeline (WIDTH=16, SEG=4).
module tb_approx_lookahead_adder_pipe;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    approx_lookahead_adder_pipe_if #(.WIDTH(16), .CNT_W(16)) bus ();
    approx_lookahead_adder_pipe_if #(.WIDTH(16), .CNT_W(2))  bus2 ();

    approx_lookahead_adder_pipe #(.WIDTH(16), .SEG(4), .CNT_W(16)) u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    approx_lookahead_adder_pipe #(.WIDTH(16), .SEG(4), .CNT_W(2)) u_dut_sat (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c0;
        logic [15:0] s;
        logic        cout;
        logic        err;
    } vec_t;

    vec_t vecs[7];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic c0);
        int waited;
        @(negedge CLK);
        bus.A = a;
        bus.B = b;
        bus.C0 = c0;
        bus.IN_VALID = 1'b1;
        #1;
        waited = 0;
        while (!bus.IN_READY && waited < 20) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        check("push_ready", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.OUT_VALID && cyc < 10) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int exp_cnt;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'h000C, 16'h000C, 1'b0, 16'h0018, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFF0, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h00F0, 1'b0, 1'b1};
        vecs[5] = '{16'h000C, 16'h0004, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};

        bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.C0 = 1'b0;
        bus.OUT_READY = 1'b0; bus.CNT_CLR = 1'b0;
        bus2.IN_VALID = 1'b0; bus2.A = '0; bus2.B = '0; bus2.C0 = 1'b0;
        bus2.OUT_READY = 1'b0; bus2.CNT_CLR = 1'b0;

        // Reset state
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check("rst_s", {16'd0, bus.S}, 32'd0);
        check("rst_cout", {31'd0, bus.COUT}, 32'd0);
        check("rst_err", {31'd0, bus.ERR}, 32'd0);
        check("rst_err_cnt", {16'd0, bus.ERR_CNT}, 32'd0);
        check("rst_in_ready", {31'd0, bus.IN_READY}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        bus.OUT_READY = 1'b1;

        // Table vectors, one at a time, no backpressure
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].c0);
            wait_out(cyc);
            check($sformatf("v%0d_latency", i), cyc, 1);
            check($sformatf("v%0d_s", i), {16'd0, bus.S}, {16'd0, vecs[i].s});
            check($sformatf("v%0d_cout", i), {31'd0, bus.COUT}, {31'd0, vecs[i].cout});
            check($sformatf("v%0d_err", i), {31'd0, bus.ERR}, {31'd0, vecs[i].err});
            if (vecs[i].err) exp_cnt++;
            @(posedge CLK);
            #1;
            check($sformatf("v%0d_drain", i), {31'd0, bus.OUT_VALID}, 32'd0);
        end
        check("cnt_after_table", {16'd0, bus.ERR_CNT}, exp_cnt);

        // Third error delivery
        push(16'hFFFF, 16'h0000, 1'b1);
        wait_out(cyc);
        check("err3_err", {31'd0, bus.ERR}, 32'd1);
        @(posedge CLK);
        #1;
        check("cnt_three", {16'd0, bus.ERR_CNT}, 32'd3);

        // Backpressure: three back-to-back operands with OUT_READY low
        bus.OUT_READY = 1'b0;
        @(negedge CLK);
        bus.A = 16'h1234; bus.B = 16'h4321; bus.C0 = 1'b0; bus.IN_VALID = 1'b1;
        @(posedge CLK); #1;
        bus.A = 16'h0001; bus.B = 16'h0002; bus.C0 = 1'b0;
        @(posedge CLK); #1;
        bus.A = 16'h8000; bus.B = 16'h8000; bus.C0 = 1'b0;
        check("bp_full_ready", {31'd0, bus.IN_READY}, 32'd0);
        check("bp_full_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        check("bp_full_s", {16'd0, bus.S}, 32'h5555);
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            check("bp_hold_ready", {31'd0, bus.IN_READY}, 32'd0);
            check("bp_hold_valid", {31'd0, bus.OUT_VALID}, 32'd1);
            check("bp_hold_s", {16'd0, bus.S}, 32'h5555);
            check("bp_hold_err", {31'd0, bus.ERR}, 32'd0);
        end
        bus.OUT_READY = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, bus.IN_READY}, 32'd1);
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        check("bp_second_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        check("bp_second_s", {16'd0, bus.S}, 32'h0003);
        @(posedge CLK); #1;
        check("bp_third_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        check("bp_third_s", {16'd0, bus.S}, 32'h0000);
        check("bp_third_cout", {31'd0, bus.COUT}, 32'd1);
        @(posedge CLK); #1;
        check("bp_empty", {31'd0, bus.OUT_VALID}, 32'd0);
        check("bp_cnt", {16'd0, bus.ERR_CNT}, 32'd3);

        // Reset with both stages full
        bus.OUT_READY = 1'b0;
        push(16'h000C, 16'h000C, 1'b0);
        push(16'hFFFF, 16'h0000, 1'b1);
        check("mid_full_ready", {31'd0, bus.IN_READY}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.IN_READY}, 32'd0);
        @(posedge CLK); #1;
        check("mid_rst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check("mid_rst_cnt", {16'd0, bus.ERR_CNT}, 32'd0);
        check("mid_rst_s", {16'd0, bus.S}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, bus.IN_READY}, 32'd1);
        bus.OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("mid_rel_flushed", {31'd0, bus.OUT_VALID}, 32'd0);

        // Clear coincident with an error delivery
        push(16'hFFFF, 16'h0000, 1'b1);
        wait_out(cyc);
        @(posedge CLK); #1;
        check("clr_pre_cnt", {16'd0, bus.ERR_CNT}, 32'd1);
        push(16'h00FF, 16'h0001, 1'b0);
        wait_out(cyc);
        check("clr_err_present", {31'd0, bus.ERR}, 32'd1);
        bus.CNT_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.CNT_CLR = 1'b0;
        check("clr_priority", {16'd0, bus.ERR_CNT}, 32'd0);

        // Saturation on the 2-bit counter instance
        bus2.OUT_READY = 1'b1;
        @(negedge CLK);
        bus2.A = 16'hFFFF; bus2.B = 16'h0000; bus2.C0 = 1'b1; bus2.IN_VALID = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        bus2.IN_VALID = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("sat_cnt", {30'd0, bus2.ERR_CNT}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
